// File: rtl/ddr_out_serialiser_pkg.sv
// Shared constants and sizing helpers for the DDR/SDR lane serialiser.
package ddr_out_serialiser_pkg;

  localparam logic MODE_DDR = 1'b1;
  localparam logic MODE_SDR = 1'b0;

  function automatic int beat_count(input int w_word, input int w_lanes);
    return w_word / w_lanes;
  endfunction

  // One extra bit so the counter can hold the full beat count of a fresh word.
  function automatic int cnt_width(input int beats);
    return $clog2(beats) + 1;
  endfunction

endpackage

// File: rtl/cell_ddr_out.sv
// Single-bit DDR output cell: dp shown during the high phase, dn during the low phase.
module cell_ddr_out #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dp,
  input  logic dn,
  output logic q
);

  logic dp_r;
  logic dn_r;

  // Capture both phase values together on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_r <= RESET_VALUE;
      dn_r <= RESET_VALUE;
    end else begin
      dp_r <= dp;
      dn_r <= dn;
    end
  end

  assign q = clk ? dp_r : dn_r;

endmodule

// File: rtl/ddr_out_serialiser.sv
// Word-to-lane serialiser with a one-entry holding register feeding a beat shifter
// that drives one DDR output cell per lane.
module ddr_out_serialiser
  import ddr_out_serialiser_pkg::*;
#(
  parameter int                 W_LANES    = 4,
  parameter int                 W_WORD     = 32,
  parameter logic [W_LANES-1:0] IDLE_VALUE = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_ddr,
  input  logic               cfg_msb_first,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W_WORD-1:0]  in_data,
  output logic [W_LANES-1:0] out_q,
  output logic [W_LANES-1:0] out_oe,
  output logic               busy
);

  localparam int             BEATS    = beat_count(W_WORD, W_LANES);
  localparam int             CW       = cnt_width(BEATS);
  localparam logic [CW-1:0]  CNT_FULL = CW'(BEATS);
  localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_TWO  = CW'(2);

  if (W_LANES < 1 || W_LANES > 8) begin : g_bad_lanes
    $error("ddr_out_serialiser: W_LANES must be in 1..8");
  end
  if (W_WORD % (2 * W_LANES) != 0) begin : g_bad_word
    $error("ddr_out_serialiser: W_WORD must be a multiple of 2*W_LANES");
  end

  logic               hold_valid_r;
  logic [W_WORD-1:0]  hold_data_r;
  logic               hold_ddr_r;
  logic               hold_msb_r;

  logic [W_WORD-1:0]  sr_r;
  logic [CW-1:0]      sr_cnt_r;
  logic               sr_ddr_r;
  logic               sr_msb_r;
  logic               oe_r;

  logic               sr_active_s;
  logic               sr_last_s;
  logic               accept_s;
  logic               load_s;
  logic [CW-1:0]      step_s;
  logic [W_LANES-1:0] beat0_s;
  logic [W_LANES-1:0] beat1_s;
  logic [W_LANES-1:0] dp_s;
  logic [W_LANES-1:0] dn_s;

  assign sr_active_s = (sr_cnt_r != CNT_ZERO);
  assign accept_s    = in_valid && !hold_valid_r;
  // Reloading on the final cycle of a word is what makes back-to-back words gapless.
  assign load_s      = hold_valid_r && (!sr_active_s || sr_last_s);

  // Per-cycle beat advance and final-cycle detection for the word in the shifter.
  always_comb begin
    if (sr_ddr_r == MODE_DDR) begin
      step_s    = CNT_TWO;
      sr_last_s = (sr_cnt_r == CNT_TWO);
    end else begin
      step_s    = CNT_ONE;
      sr_last_s = (sr_cnt_r == CNT_ONE);
    end
  end

  // Pick the next two beats from the end of the shifter that matches the beat order.
  always_comb begin
    if (sr_msb_r) begin
      beat0_s = sr_r[W_WORD-1 -: W_LANES];
      beat1_s = sr_r[W_WORD-W_LANES-1 -: W_LANES];
    end else begin
      beat0_s = sr_r[W_LANES-1:0];
      beat1_s = sr_r[2*W_LANES-1 -: W_LANES];
    end
  end

  // Cell phase inputs: idle level when empty, beat pair in DDR, repeated beat in SDR.
  always_comb begin
    if (!sr_active_s) begin
      dp_s = IDLE_VALUE;
      dn_s = IDLE_VALUE;
    end else if (sr_ddr_r == MODE_DDR) begin
      dp_s = beat0_s;
      dn_s = beat1_s;
    end else begin
      dp_s = beat0_s;
      dn_s = beat0_s;
    end
  end

  // Holding register: filled by the input handshake, emptied by a shifter load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_r <= 1'b0;
      hold_data_r  <= '0;
      hold_ddr_r   <= MODE_SDR;
      hold_msb_r   <= 1'b0;
    end else if (accept_s) begin
      hold_valid_r <= 1'b1;
      hold_data_r  <= in_data;
      hold_ddr_r   <= cfg_ddr;
      hold_msb_r   <= cfg_msb_first;
    end else if (load_s) begin
      hold_valid_r <= 1'b0;
    end
  end

  // Beat shifter with remaining-beat counter; mode bits are frozen per word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_r     <= '0;
      sr_cnt_r <= CNT_ZERO;
      sr_ddr_r <= MODE_SDR;
      sr_msb_r <= 1'b0;
    end else if (load_s) begin
      sr_r     <= hold_data_r;
      sr_cnt_r <= CNT_FULL;
      sr_ddr_r <= hold_ddr_r;
      sr_msb_r <= hold_msb_r;
    end else if (sr_active_s) begin
      sr_cnt_r <= sr_cnt_r - step_s;
      if (sr_msb_r) begin
        sr_r <= (sr_ddr_r == MODE_DDR) ? (sr_r << (2 * W_LANES)) : (sr_r << W_LANES);
      end else begin
        sr_r <= (sr_ddr_r == MODE_DDR) ? (sr_r >> (2 * W_LANES)) : (sr_r >> W_LANES);
      end
    end
  end

  // Output enable registered on the same edge the cells capture a beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_r <= 1'b0;
    end else begin
      oe_r <= sr_active_s;
    end
  end

  for (genvar i = 0; i < W_LANES; i++) begin : g_lane
    cell_ddr_out #(
      .RESET_VALUE(IDLE_VALUE[i])
    ) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .dp   (dp_s[i]),
      .dn   (dn_s[i]),
      .q    (out_q[i])
    );
  end

  assign in_ready = !hold_valid_r;
  assign out_oe   = {W_LANES{oe_r}};
  assign busy     = hold_valid_r || sr_active_s || oe_r;

endmodule

// File: tb/tb_ddr_out_serialiser.sv
// Randomised and directed bench for ddr_out_serialiser against a phase-sequence model.
module tb_ddr_out_serialiser;

  localparam int PERIOD = 10;

  logic        clk;
  logic        rst_n;
  logic        cfg_ddr;
  logic        cfg_msb_first;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  out_q;
  logic [3:0]  out_oe;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] w_q[$];
  bit          d_q[$];
  bit          m_q[$];

  ddr_out_serialiser #(
    .W_LANES   (4),
    .W_WORD    (16),
    .IDLE_VALUE(4'h0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_ddr      (cfg_ddr),
    .cfg_msb_first(cfg_msb_first),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_q        (out_q),
    .out_oe       (out_oe),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #(PERIOD / 2) clk = ~clk;

  initial begin
    #(PERIOD * 20000);
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  // Beat k of a 16-bit word as 4-bit nibbles, in the requested order.
  function automatic logic [3:0] beat_of(input logic [15:0] w, input bit msb, input int k);
    int sh;
    sh = msb ? (12 - 4 * k) : (4 * k);
    return 4'((w >> sh) & 16'h000F);
  endfunction

  // Sends w_q/d_q/m_q back-to-back and checks the pin phases against the model.
  task automatic run_words(input string name);
    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];
    time        t_acc;
    time        t_oe;
    int         n_cyc;
    bit         found;
    exp_q.delete();
    for (int i = 0; i < w_q.size(); i++) begin
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back(beat_of(w_q[i], m_q[i], k));
        if (!d_q[i]) exp_q.push_back(beat_of(w_q[i], m_q[i], k));
      end
    end
    t_acc = 0;
    t_oe  = 0;
    n_cyc = 0;
    found = 1'b0;
    fork
      begin : driver
        bit rdy;
        bit acc;
        for (int i = 0; i < w_q.size(); i++) begin
          in_valid      = 1'b1;
          in_data       = w_q[i];
          cfg_ddr       = d_q[i];
          cfg_msb_first = m_q[i];
          acc = 1'b0;
          for (int c = 0; c < 60 && !acc; c++) begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) acc = 1'b1;
          end
          checks++;
          if (!acc) begin
            errors++;
            $display("FAIL %s_accept: word %0d not accepted, got in_ready=%b required 1", name, i, in_ready);
          end
          if (i == 0) t_acc = $time;
          #1;
          // Scramble the mode pins after every accept; the word in flight must not notice.
          cfg_ddr       = 1'($urandom);
          cfg_msb_first = 1'($urandom);
        end
        in_valid = 1'b0;
        in_data  = 16'($urandom);
      end
      begin : collector
        for (int c = 0; c < 60 && !found; c++) begin
          @(posedge clk);
          #3;
          if (out_oe !== 4'h0) found = 1'b1;
        end
        checks++;
        if (!found) begin
          errors++;
          $display("FAIL %s_oe_rise: out_oe stayed %h, required F", name, out_oe);
        end else begin
          t_oe = $time - 3;
          while (out_oe !== 4'h0 && n_cyc < 200) begin
            checks++;
            if (out_oe !== 4'hF) begin
              errors++;
              $display("FAIL %s_oe_bits: got %h required F", name, out_oe);
            end
            obs_q.push_back(out_q);
            @(negedge clk);
            #3;
            obs_q.push_back(out_q);
            n_cyc++;
            @(posedge clk);
            #3;
          end
          checks++;
          if (out_q !== 4'h0) begin
            errors++;
            $display("FAIL %s_idle_level: got %h required 0", name, out_q);
          end
          checks++;
          if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_after: got %b required 0", name, busy);
          end
        end
      end
    join
    if (found) begin
      checks++;
      if (t_oe - t_acc != 2 * PERIOD) begin
        errors++;
        $display("FAIL %s_latency: oe rose %0t after accept, required %0d", name, t_oe - t_acc, 2 * PERIOD);
      end
      checks++;
      if (n_cyc != exp_q.size() / 2) begin
        errors++;
        $display("FAIL %s_oe_cycles: got %0d required %0d", name, n_cyc, exp_q.size() / 2);
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL %s_phase_count: got %0d required %0d", name, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s_phase%0d: got %h required %h", name, i, obs_q[i], exp_q[i]);
        end
      end
    end
    w_q.delete();
    d_q.delete();
    m_q.delete();
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    in_data       = 16'h0000;
    cfg_ddr       = 1'b0;
    cfg_msb_first = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_q !== 4'h0 || out_oe !== 4'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got q=%h oe=%h busy=%b rdy=%b required q=0 oe=0 busy=0 rdy=1",
               out_q, out_oe, busy, in_ready);
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ddr_msb();
    w_q.push_back(16'h1234); d_q.push_back(1'b1); m_q.push_back(1'b1);
    run_words("ddr_msb");
  endtask

  task automatic test_ddr_lsb();
    w_q.push_back(16'h1234); d_q.push_back(1'b1); m_q.push_back(1'b0);
    run_words("ddr_lsb");
  endtask

  task automatic test_sdr_msb();
    w_q.push_back(16'hA5C3); d_q.push_back(1'b0); m_q.push_back(1'b1);
    run_words("sdr_msb");
  endtask

  task automatic test_back_to_back();
    w_q.push_back(16'h1234); d_q.push_back(1'b1); m_q.push_back(1'b1);
    w_q.push_back(16'hABCD); d_q.push_back(1'b1); m_q.push_back(1'b1);
    run_words("back_to_back");
  endtask

  task automatic test_mode_change();
    w_q.push_back(16'h1234); d_q.push_back(1'b1); m_q.push_back(1'b1);
    w_q.push_back(16'h5678); d_q.push_back(1'b0); m_q.push_back(1'b1);
    run_words("mode_change");
  endtask

  task automatic test_reset_mid_word();
    bit rdy;
    bit found;
    in_valid      = 1'b1;
    in_data       = 16'h1234;
    cfg_ddr       = 1'b1;
    cfg_msb_first = 1'b1;
    rdy = 1'b0;
    for (int c = 0; c < 10 && !rdy; c++) begin
      rdy = in_ready;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(posedge clk);
      #3;
      if (out_oe === 4'hF) found = 1'b1;
    end
    checks++;
    if (!found || out_q !== 4'h1) begin
      errors++;
      $display("FAIL rst_mid_first_beat: got q=%h oe=%h required q=1 oe=F", out_q, out_oe);
    end
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_q !== 4'h0 || out_oe !== 4'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_async: got q=%h oe=%h busy=%b rdy=%b required q=0 oe=0 busy=0 rdy=1",
               out_q, out_oe, busy, in_ready);
    end
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_release: got rdy=%b busy=%b required rdy=1 busy=0", in_ready, busy);
    end
    w_q.push_back(16'h00FF); d_q.push_back(1'b1); m_q.push_back(1'b1);
    run_words("after_reset");
  endtask

  task automatic test_random();
    int n;
    for (int b = 0; b < 20; b++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        w_q.push_back(16'($urandom));
        d_q.push_back(1'($urandom));
        m_q.push_back(1'($urandom));
      end
      run_words($sformatf("random%0d", b));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_ddr_msb();
    test_ddr_lsb();
    test_sdr_msb();
    test_back_to_back();
    test_mode_change();
    test_reset_mid_word();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
